// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//
// Shared definitions for the GPIO input-conditioning path.
//
// Contents:
//   GPIO_MAX_PINS         - widest pin bus the GPIO block supports
//   GPIO_SYNC_STAGES_DEF  - default synchronizer depth
//   GPIO_DEBOUNCE_DEF     - default number of stable cycles before a commit
//   GPIO_CNT_WIDTH_DEF    - default debounce counter width
//   gpio_state_e          - per-pin debounce state (STABLE / PENDING / COMMIT)
//   gpio_classify()       - maps (mismatch, counter-at-limit) onto a state
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int unsigned GPIO_MAX_PINS        = 32;
  localparam int unsigned GPIO_SYNC_STAGES_DEF = 2;
  localparam int unsigned GPIO_DEBOUNCE_DEF    = 16;
  localparam int unsigned GPIO_CNT_WIDTH_DEF   = 16;

  // Encoding is fixed so coverage collectors can decode it by value.
  typedef enum logic [1:0] {
    StStable  = 2'd0,
    StPending = 2'd1,
    StCommit  = 2'd2
  } gpio_state_e;

  // mismatch : synchronized input differs from the debounced level
  // at_limit : counter has reached DEBOUNCE_CYCLES-1
  function automatic gpio_state_e gpio_classify(input logic mismatch,
                                                input logic at_limit);
    gpio_state_e st;
    if (!mismatch) begin
      st = StStable;
    end else if (at_limit) begin
      st = StCommit;
    end else begin
      st = StPending;
    end
    return st;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
//
// Conditioning for one GPIO pin: multi-flop synchronizer, saturating debounce
// counter, debounced level register and (optionally) registered edge strobes.
//
// Configuration macro:
//   GPIO_DEBOUNCE_EDGE_EN - when defined, the edge-history register and the
//                           redge_o / fedge_o strobes are built; otherwise both
//                           strobes are tied low.
//
// Parameters:
//   SYNC_STAGES     - synchronizer depth (2..4)
//   DEBOUNCE_CYCLES - consecutive mismatching cycles needed to commit (1..65535)
//   CNT_WIDTH       - counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//
// Ports:
//   clk      in  - clock
//   rst_n    in  - asynchronous active-low reset
//   raw_i    in  - asynchronous pad input
//   bypass_i in  - 1: level follows the synchronizer output directly
//   level_o  out - debounced level
//   redge_o  out - one-cycle pulse, cycle after level_o rises
//   fedge_o  out - one-cycle pulse, cycle after level_o falls
// -----------------------------------------------------------------------------
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
  parameter int unsigned CNT_WIDTH       = GPIO_CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic bypass_i,
  output logic level_o,
  output logic redge_o,
  output logic fedge_o
);

  localparam logic [CNT_WIDTH-1:0] CntLimit = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce state machine
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 level_q;
  logic                 mismatch;
  logic                 at_limit;
  gpio_state_e          state;

  assign mismatch = sync ^ level_q;
  assign at_limit = (cnt_q == CntLimit);
  assign state    = gpio_classify(mismatch, at_limit);

  // Counter only advances on consecutive mismatches and saturates at the
  // commit point, so it can never wrap. Any return to the current level
  // clears it: there is no partial credit for a glitchy input. Bypass also
  // holds it at zero, so leaving bypass can never land straight on a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (bypass_i) begin
      cnt_q   <= '0;
      level_q <= sync;
    end else begin
      unique case (state)
        StStable: begin
          cnt_q <= '0;
        end
        StPending: begin
          cnt_q <= cnt_q + CntOne;
        end
        StCommit: begin
          cnt_q   <= '0;
          level_q <= sync;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;

  // ---------------------------------------------------------------------------
  // Edge strobes: registered compare of the level against its previous value,
  // so each pulse appears the cycle after level_o changes and lasts one cycle.
  // ---------------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic level_prev_q;
  logic redge_q;
  logic fedge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
      redge_q      <= 1'b0;
      fedge_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      redge_q      <= level_q & ~level_prev_q;
      fedge_q      <= ~level_q & level_prev_q;
    end
  end

  assign redge_o = redge_q;
  assign fedge_o = fedge_q;
`else
  assign redge_o = 1'b0;
  assign fedge_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
//
// Input conditioning for the GPIO register block. Each raw pad input is
// synchronized and debounced independently; the debounced bus drives the
// register block's gpio_i. Optional edge strobes feed interrupt logic.
//
// Configuration macro:
//   GPIO_DEBOUNCE_EDGE_EN - defined: redge_o / fedge_o are generated.
//                           undefined: redge_o / fedge_o are tied to 0; the
//                           port list is the same in both builds.
//
// Parameters:
//   NUM_GPIO        - number of pins (1..32)
//   SYNC_STAGES     - synchronizer depth (2..4)
//   DEBOUNCE_CYCLES - required stable cycles (1..65535)
//   CNT_WIDTH       - counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//
// Ports:
//   clk         in  - sole clock
//   rst_n       in  - asynchronous active-low reset
//   gpio_raw_i  in  - [NUM_GPIO] asynchronous pad inputs
//   bypass_i    in  - [NUM_GPIO] quasi-static per-pin debounce bypass
//   gpio_o      out - [NUM_GPIO] debounced level
//   redge_o     out - [NUM_GPIO] one-cycle rising-edge strobe
//   fedge_o     out - [NUM_GPIO] one-cycle falling-edge strobe
// -----------------------------------------------------------------------------
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO        = 1,
  parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
  parameter int unsigned CNT_WIDTH       = GPIO_CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_GPIO-1:0] gpio_raw_i,
  input  logic [NUM_GPIO-1:0] bypass_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] redge_o,
  output logic [NUM_GPIO-1:0] fedge_o
);

  // Pins share nothing but clock and reset; simultaneous commits on several
  // pins each produce their own strobe.
  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (gpio_raw_i[i]),
      .bypass_i (bypass_i[i]),
      .level_o  (gpio_o[i]),
      .redge_o  (redge_o[i]),
      .fedge_o  (fedge_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// -----------------------------------------------------------------------------
// tb_gpio_debounce
//
// Directed scenarios on a 4-pin, 2-stage, 8-cycle debounce instance. Each
// scenario drives the pins edge by edge (edge 1 is the first clock edge after
// reset release) and pushes the expected outputs for that edge into a
// scoreboard queue; the entry is popped and compared just after the edge.
// Expected levels are written in closed form from the debounce timing; the
// strobes expected at edge e are derived from the expected levels at e-1, e-2.
// -----------------------------------------------------------------------------
module tb_gpio_debounce;

  localparam int unsigned N = 4;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] gpio;
    logic [N-1:0] redge;
    logic [N-1:0] fedge;
  } obs_t;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [N-1:0] gpio_raw_i = '0;
  logic [N-1:0] bypass_i   = '0;
  logic [N-1:0] gpio_o;
  logic [N-1:0] redge_o;
  logic [N-1:0] fedge_o;

  obs_t         sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] g1 = '0;  // expected level after the previous edge
  logic [N-1:0] g2 = '0;  // expected level two edges back

  gpio_debounce #(
    .NUM_GPIO        (N),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_WIDTH       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_raw_i (gpio_raw_i),
    .bypass_i   (bypass_i),
    .gpio_o     (gpio_o),
    .redge_o    (redge_o),
    .fedge_o    (fedge_o)
  );

  always #5 clk = ~clk;

  // Push the expectation for the coming edge given the expected level there.
  task automatic push_exp(input logic [N-1:0] g);
    obs_t e;
    e.gpio  = g;
    e.redge = EdgeEn ? (g1 & ~g2) : '0;
    e.fedge = EdgeEn ? (~g1 & g2) : '0;
    sb_q.push_back(e);
    g2 = g1;
    g1 = g;
  endtask

  // Hold reset for a few edges, then release 1 ns after an edge.
  task automatic do_reset(input logic [N-1:0] raw, input logic [N-1:0] byp);
    rst_n      = 1'b0;
    gpio_raw_i = raw;
    bypass_i   = byp;
    g1         = '0;
    g2         = '0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic raw2_pattern(input int e);
    if (e < 1 || e > 30) return 1'b0;
    return logic'(((e - 1) / 3) % 2);
  endfunction

  task automatic test_reset();
    obs_t got;
    obs_t want;
    rst_n      = 1'b0;
    gpio_raw_i = '1;
    bypass_i   = '1;
    repeat (3) @(posedge clk);
    #1;
    got = {gpio_o, redge_o, fedge_o};
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_held: got %b want %b", got, obs_t'(0));
    end
    do_reset('0, '0);
    for (int e = 1; e <= 100; e++) begin
      push_exp('0);
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset_idle e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  // Pin 0 high from edge 10 to 29, low from 30: commit at 19 and 39.
  task automatic test_single_rise_fall();
    obs_t got;
    obs_t want;
    do_reset('0, '0);
    for (int e = 1; e <= 45; e++) begin
      gpio_raw_i = {3'b000, (e >= 10 && e < 30)};
      push_exp({3'b000, (e >= 19 && e < 39)});
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL single_rise_fall e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  // Pin 1: high 10..14, low at 15, high again from 16. The glitch clears the
  // count, so the commit lands at 16+1+8 = 25.
  task automatic test_glitch();
    obs_t got;
    obs_t want;
    do_reset('0, '0);
    for (int e = 1; e <= 32; e++) begin
      gpio_raw_i = {2'b00, ((e >= 10 && e <= 14) || e >= 16), 1'b0};
      push_exp({2'b00, (e >= 25), 1'b0});
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL glitch e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  // Pin 2 toggles every 3 edges in bypass (2-edge latency) until edge 24, then
  // bypass drops. Short runs (<8) never commit; raw held low from 31 commits
  // at 31+1+8 = 40.
  task automatic test_bypass();
    obs_t         got;
    obs_t         want;
    logic         g;
    do_reset('0, 4'b0100);
    for (int e = 1; e <= 45; e++) begin
      gpio_raw_i = {1'b0, raw2_pattern(e), 2'b00};
      bypass_i   = {1'b0, (e <= 24), 2'b00};
      if (e <= 24)      g = raw2_pattern(e - 2);
      else if (e <= 39) g = 1'b1;
      else              g = 1'b0;
      push_exp({1'b0, g, 2'b00});
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL bypass e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  // Pin 0 committed high, pin 3 four edges into a pending rise, then reset.
  // With both pins held high across release, the first post-release edge
  // samples them, so both commit together at edge 10.
  task automatic test_reset_mid_pending();
    obs_t got;
    obs_t want;
    do_reset('0, '0);
    for (int e = 1; e <= 15; e++) begin
      gpio_raw_i = {(e >= 10), 2'b00, 1'b1};
      push_exp({3'b000, (e >= 10)});
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL pre_reset e=%0d: got %b want %b", e, got, want);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {gpio_o, redge_o, fedge_o};
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset: got %b want %b", got, obs_t'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    g1    = '0;
    g2    = '0;
    for (int e = 1; e <= 14; e++) begin
      push_exp((e >= 10) ? 4'b1001 : 4'b0000);
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL post_reset e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  // All pins toggled together: simultaneous commits at 10 and 30.
  task automatic test_all_pins();
    obs_t got;
    obs_t want;
    do_reset('0, '0);
    for (int e = 1; e <= 35; e++) begin
      gpio_raw_i = (e <= 20) ? 4'hF : 4'h0;
      push_exp((e >= 10 && e < 30) ? 4'hF : 4'h0);
      @(posedge clk);
      #1;
      got  = {gpio_o, redge_o, fedge_o};
      want = sb_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL all_pins e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise_fall();
    test_glitch();
    test_bypass();
    test_reset_mid_pending();
    test_all_pins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
